// File: rtl/vram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vram_pkg
// Description : Shared constants and types for the video/keyboard RAM port-A
//               arbiter. Holds the RAM geometry, read latency, requester ids
//               and the read-return tag layout.
// Revision    : 1.0  initial release
// ============================================================================
package vram_pkg;

  localparam int VRAM_ADDR_W = 14;   // 16K words
  localparam int VRAM_DATA_W = 8;    // byte-wide RAM
  localparam int VRAM_RD_LAT = 2;    // cea -> douta with output register enabled

  // Requester ids carried alongside each in-flight read
  localparam logic REQ_CPU  = 1'b0;  // r0: Z80 bus interface
  localparam logic REQ_HOST = 1'b1;  // r1: host / loader

  // One entry of the read-return pipe
  typedef struct packed {
    logic valid;  // 1 = granted read, 0 = bubble or write
    logic id;     // requester that issued the read
  } rd_tag_t;

endpackage
`default_nettype wire

// File: rtl/vram_rd_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module      : vram_rd_tag_pipe
// Description : RD_LAT-stage shift register of read tags {valid, id}. A tag
//               entering on the grant cycle leaves the last stage exactly in
//               the cycle the RAM presents the matching read data.
// Ports       : clk      - system clock
//               reset_n  - asynchronous active-low clear of every stage
//               tag_in   - tag for the access granted this cycle
//               tag_out  - tag aligned with the current RAM read data
// Revision    : 1.0  initial release
// ============================================================================
module vram_rd_tag_pipe
  import vram_pkg::*;
#(
  parameter int RD_LAT = VRAM_RD_LAT
) (
  input  logic    clk,
  input  logic    reset_n,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t [RD_LAT-1:0] stage_q;
  rd_tag_t [RD_LAT-1:0] stage_d;

  always_comb begin
    stage_d    = stage_q;
    stage_d[0] = tag_in;
    for (int i = 1; i < RD_LAT; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Clearing here is what discards in-flight reads on a mid-operation reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign tag_out = stage_q[RD_LAT-1];

endmodule
`default_nettype wire

// File: rtl/vram_porta_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vram_porta_arbiter
// Description : Shares port A of the 16K x 8 dual-port video/keyboard RAM
//               between r0 (Z80 bus, priority) and r1 (host/loader). One
//               access per clock; r1 is forced ahead after STARVE_MAX blocked
//               cycles. Read data returns RD_LAT cycles after the grant,
//               steered to the requester by a tag pipe.
// Ports       : clk, reset_n                 - clock, async active-low reset
//               r0_* / r1_*                  - requester interfaces
//                 req/we/addr/wdata  in      - held until gnt
//                 gnt                out     - accepted this cycle
//                 rvalid/rdata       out     - read return (rdata 0 when idle)
//               ram_ada/dina/cea/wrea out    - RAM port-A access controls
//               ram_ocea, ram_reseta  out    - RAM output reg enable / reset
//               ram_douta             in     - RAM port-A read data
// Revision    : 1.0  initial release
// ============================================================================
module vram_porta_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_W     = VRAM_ADDR_W,
  parameter int DATA_W     = VRAM_DATA_W,
  parameter int RD_LAT     = VRAM_RD_LAT,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  // r0: Z80 bus interface
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  // r1: host / loader
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  // RAM port A
  output logic [ADDR_W-1:0] ram_ada,
  output logic [DATA_W-1:0] ram_dina,
  output logic              ram_cea,
  output logic              ram_wrea,
  output logic              ram_ocea,
  output logic              ram_reseta,
  input  logic [DATA_W-1:0] ram_douta
);

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  logic [7:0]        starve_cnt_q, starve_cnt_d;
  logic [ADDR_W-1:0] ada_q, ada_d;
  logic [DATA_W-1:0] dina_q, dina_d;
  logic              gnt0, gnt1;
  logic              wrea;
  rd_tag_t           tag_in, tag_out;

  // --------------------------------------------------------------------------
  // Arbitration. Gated by reset_n so grants and RAM strobes drop the moment
  // reset asserts, not at the next edge.
  // --------------------------------------------------------------------------
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (reset_n) begin
      if (r0_req && r1_req) begin
        if (starve_cnt_q == STARVE_LIM) begin
          gnt1 = 1'b1;
        end else begin
          gnt0 = 1'b1;
        end
      end else if (r0_req) begin
        gnt0 = 1'b1;
      end else if (r1_req) begin
        gnt1 = 1'b1;
      end
    end
  end

  // Counts consecutive blocked r1 cycles; any r1 grant or a dropped r1
  // request restarts the count.
  always_comb begin
    starve_cnt_d = 8'd0;
    if (r1_req && !gnt1) begin
      starve_cnt_d = (starve_cnt_q == STARVE_LIM) ? starve_cnt_q : starve_cnt_q + 8'd1;
    end
  end

  // RAM address/data follow the winner; with no grant they keep the last
  // driven value so the RAM pins do not toggle needlessly.
  always_comb begin
    ada_d  = ada_q;
    dina_d = dina_q;
    wrea   = 1'b0;
    if (gnt0) begin
      ada_d  = r0_addr;
      dina_d = r0_wdata;
      wrea   = r0_we;
    end else if (gnt1) begin
      ada_d  = r1_addr;
      dina_d = r1_wdata;
      wrea   = r1_we;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt_q <= 8'd0;
      ada_q        <= '0;
      dina_q       <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      ada_q        <= ada_d;
      dina_q       <= dina_d;
    end
  end

  assign r0_gnt     = gnt0;
  assign r1_gnt     = gnt1;
  assign ram_cea    = gnt0 | gnt1;
  assign ram_wrea   = wrea;
  assign ram_ada    = ada_d;
  assign ram_dina   = dina_d;
  assign ram_ocea   = reset_n;
  assign ram_reseta = ~reset_n;

  // --------------------------------------------------------------------------
  // Read return: writes enter the pipe as bubbles so they never raise rvalid.
  // --------------------------------------------------------------------------
  always_comb begin
    tag_in.valid = (gnt0 | gnt1) & ~wrea;
    tag_in.id    = gnt1 ? REQ_HOST : REQ_CPU;
  end

  vram_rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_tag_pipe (
    .clk     (clk),
    .reset_n (reset_n),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign r0_rvalid = tag_out.valid && (tag_out.id == REQ_CPU);
  assign r1_rvalid = tag_out.valid && (tag_out.id == REQ_HOST);
  assign r0_rdata  = r0_rvalid ? ram_douta : '0;
  assign r1_rdata  = r1_rvalid ? ram_douta : '0;

endmodule
`default_nettype wire

// File: tb/tb_vram_porta_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_vram_porta_arbiter
// Description : Directed self-checking bench for vram_porta_arbiter with a
//               behavioural 16K x 8 port-A RAM (2-cycle read, output register,
//               normal write mode).
// Revision    : 1.0  initial release
// ============================================================================
module tb_vram_porta_arbiter;

  logic        clk;
  logic        reset_n;
  logic        r0_req, r0_we, r1_req, r1_we;
  logic [13:0] r0_addr, r1_addr;
  logic [7:0]  r0_wdata, r1_wdata;
  logic        r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
  logic [7:0]  r0_rdata, r1_rdata;
  logic [13:0] ram_ada;
  logic [7:0]  ram_dina, ram_douta;
  logic        ram_cea, ram_wrea, ram_ocea, ram_reseta;

  int n_cmp = 0;
  int n_err = 0;

  vram_porta_arbiter dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .r0_req     (r0_req),
    .r0_we      (r0_we),
    .r0_addr    (r0_addr),
    .r0_wdata   (r0_wdata),
    .r0_gnt     (r0_gnt),
    .r0_rvalid  (r0_rvalid),
    .r0_rdata   (r0_rdata),
    .r1_req     (r1_req),
    .r1_we      (r1_we),
    .r1_addr    (r1_addr),
    .r1_wdata   (r1_wdata),
    .r1_gnt     (r1_gnt),
    .r1_rvalid  (r1_rvalid),
    .r1_rdata   (r1_rdata),
    .ram_ada    (ram_ada),
    .ram_dina   (ram_dina),
    .ram_cea    (ram_cea),
    .ram_wrea   (ram_wrea),
    .ram_ocea   (ram_ocea),
    .ram_reseta (ram_reseta),
    .ram_douta  (ram_douta)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM port A: array read into stage 1, output register after
  logic [7:0] mem [0:16383];
  logic [7:0] ram_s1;
  always @(posedge clk) begin
    if (ram_reseta) begin
      ram_s1    <= 8'h00;
      ram_douta <= 8'h00;
    end else begin
      if (ram_cea) begin
        if (ram_wrea) begin
          mem[ram_ada] <= ram_dina;
          ram_s1       <= ram_dina;
        end else begin
          ram_s1 <= mem[ram_ada];
        end
      end
      if (ram_ocea) ram_douta <= ram_s1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    r0_req = 0; r0_we = 0; r0_addr = '0; r0_wdata = '0;
    r1_req = 0; r1_we = 0; r1_addr = '0; r1_wdata = '0;
  endtask

  // Advance to just after the next rising edge (input drive point)
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Read/write op tables
  logic [13:0] pa  [3];
  logic [7:0]  pd  [3];
  logic        oid [6];
  logic        owe [6];
  logic [13:0] oad [6];
  logic [7:0]  odt [6];

  initial begin
    idle();
    reset_n = 1'b0;
    r0_req  = 1'b1;                       // request during reset must not grant
    #12;
    chk("rst_r0_gnt", 32'(r0_gnt), 32'd0);
    chk("rst_cea", 32'(ram_cea), 32'd0);
    chk("rst_ocea", 32'(ram_ocea), 32'd0);
    chk("rst_reseta", 32'(ram_reseta), 32'd1);
    chk("rst_ada", 32'(ram_ada), 32'd0);
    chk("rst_r0_rdata", 32'(r0_rdata), 32'd0);
    next_cycle();
    idle();
    reset_n = 1'b1;
    @(negedge clk);
    chk("rel_ocea", 32'(ram_ocea), 32'd1);
    chk("rel_reseta", 32'(ram_reseta), 32'd0);
    chk("rel_gnt", 32'({r0_gnt, r1_gnt}), 32'd0);
    chk("rel_rvalid", 32'({r0_rvalid, r1_rvalid}), 32'd0);
    chk("rel_cea", 32'(ram_cea), 32'd0);

    // ---- r1 writes 0xA5 @0x1234, r0 reads it back -------------------------
    next_cycle();
    r1_req = 1; r1_we = 1; r1_addr = 14'h1234; r1_wdata = 8'hA5;
    @(negedge clk);
    chk("wr_r1_gnt", 32'(r1_gnt), 32'd1);
    chk("wr_r0_gnt", 32'(r0_gnt), 32'd0);
    chk("wr_cea", 32'(ram_cea), 32'd1);
    chk("wr_wrea", 32'(ram_wrea), 32'd1);
    chk("wr_ada", 32'(ram_ada), 32'h1234);
    chk("wr_dina", 32'(ram_dina), 32'hA5);
    next_cycle();
    idle();
    r0_req = 1; r0_addr = 14'h1234;
    @(negedge clk);
    chk("rd_r0_gnt", 32'(r0_gnt), 32'd1);
    chk("rd_wrea", 32'(ram_wrea), 32'd0);
    chk("rd_ada", 32'(ram_ada), 32'h1234);
    next_cycle();
    idle();
    @(negedge clk);
    chk("idle_cea", 32'(ram_cea), 32'd0);
    chk("idle_wrea", 32'(ram_wrea), 32'd0);
    chk("idle_ada_hold", 32'(ram_ada), 32'h1234);
    chk("wr_no_rvalid", 32'({r0_rvalid, r1_rvalid}), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("rd_r0_rvalid", 32'(r0_rvalid), 32'd1);
    chk("rd_r0_rdata", 32'(r0_rdata), 32'hA5);
    chk("rd_r1_rvalid", 32'(r1_rvalid), 32'd0);
    chk("rd_r1_rdata", 32'(r1_rdata), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("rd_single_pulse", 32'(r0_rvalid), 32'd0);

    // ---- Preload then pipelined r0 reads ----------------------------------
    pa[0] = 14'h0000; pd[0] = 8'h11;
    pa[1] = 14'h2000; pd[1] = 8'h22;
    pa[2] = 14'h3FFF; pd[2] = 8'h33;
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      idle();
      r1_req = 1; r1_we = 1; r1_addr = pa[k]; r1_wdata = pd[k];
    end
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      idle();
      if (c < 3) begin
        r0_req = 1; r0_addr = pa[c];
      end
      @(negedge clk);
      if (c >= 2 && c <= 4) begin
        chk($sformatf("pipe_rvalid_%0d", c), 32'(r0_rvalid), 32'd1);
        chk($sformatf("pipe_rdata_%0d", c), 32'(r0_rdata), 32'(pd[c-2]));
      end else begin
        chk($sformatf("pipe_rvalid_%0d", c), 32'(r0_rvalid), 32'd0);
      end
    end

    // ---- Interleaved ids, write bubble, read-after-write -----------------
    oid[0] = 0; owe[0] = 0; oad[0] = 14'h2000; odt[0] = 8'h22;
    oid[1] = 1; owe[1] = 0; oad[1] = 14'h0000; odt[1] = 8'h11;
    oid[2] = 0; owe[2] = 0; oad[2] = 14'h1234; odt[2] = 8'hA5;
    oid[3] = 1; owe[3] = 0; oad[3] = 14'h3FFF; odt[3] = 8'h33;
    oid[4] = 1; owe[4] = 1; oad[4] = 14'h0001; odt[4] = 8'h5A;
    oid[5] = 0; owe[5] = 0; oad[5] = 14'h0001; odt[5] = 8'h5A;
    for (int c = 0; c < 8; c++) begin
      next_cycle();
      idle();
      if (c < 6) begin
        if (oid[c] == 1'b0) begin
          r0_req = 1; r0_we = owe[c]; r0_addr = oad[c]; r0_wdata = odt[c];
        end else begin
          r1_req = 1; r1_we = owe[c]; r1_addr = oad[c]; r1_wdata = odt[c];
        end
      end
      @(negedge clk);
      if (c >= 2) begin
        if (owe[c-2]) begin
          chk($sformatf("ilv_wr_rvalid_%0d", c), 32'({r0_rvalid, r1_rvalid}), 32'd0);
        end else if (oid[c-2] == 1'b0) begin
          chk($sformatf("ilv_rvalid_%0d", c), 32'({r0_rvalid, r1_rvalid}), 32'b10);
          chk($sformatf("ilv_r0_rdata_%0d", c), 32'(r0_rdata), 32'(odt[c-2]));
        end else begin
          chk($sformatf("ilv_rvalid_%0d", c), 32'({r0_rvalid, r1_rvalid}), 32'b01);
          chk($sformatf("ilv_r1_rdata_%0d", c), 32'(r1_rdata), 32'(odt[c-2]));
        end
      end
    end

    // ---- Contention: r1 wins on every 9th cycle ---------------------------
    for (int c = 0; c < 18; c++) begin
      next_cycle();
      idle();
      r0_req = 1; r0_addr = 14'h0001;
      r1_req = 1; r1_addr = 14'h0000;
      @(negedge clk);
      chk($sformatf("cont_r1_gnt_%0d", c), 32'(r1_gnt), 32'((c % 9) == 8));
      chk($sformatf("cont_r0_gnt_%0d", c), 32'(r0_gnt), 32'((c % 9) != 8));
    end
    // Dropping r1 for a cycle restarts its starvation count
    for (int c = 0; c < 15; c++) begin
      next_cycle();
      idle();
      r0_req = 1; r0_addr = 14'h0001;
      r1_req = (c != 5); r1_addr = 14'h0000;
      @(negedge clk);
      chk($sformatf("drop_r1_gnt_%0d", c), 32'(r1_gnt), 32'(c == 14));
    end
    next_cycle();
    idle();
    next_cycle();
    next_cycle();

    // ---- Reset one cycle after a read grant -------------------------------
    next_cycle();
    r0_req = 1; r0_addr = 14'h2000;
    @(negedge clk);
    chk("mid_rd_gnt", 32'(r0_gnt), 32'd1);
    next_cycle();
    reset_n = 1'b0;
    #1;
    chk("mid_rst_gnt", 32'(r0_gnt), 32'd0);
    chk("mid_rst_cea", 32'(ram_cea), 32'd0);
    chk("mid_rst_ada", 32'(ram_ada), 32'd0);
    chk("mid_rst_ocea", 32'(ram_ocea), 32'd0);
    chk("mid_rst_reseta", 32'(ram_reseta), 32'd1);
    chk("mid_rst_rvalid", 32'({r0_rvalid, r1_rvalid}), 32'd0);
    next_cycle();
    idle();
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("mid_no_rvalid_%0d", c), 32'({r0_rvalid, r1_rvalid}), 32'd0);
      next_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Backstop in case the sequence ever stalls
  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
